// File: rtl/irq_controller.sv
// Eight-source edge-triggered interrupt controller with mask, pending,
// vector base and a single-level IDLE/ASSERT/SERVICE handshake.
module irq_controller #(
  parameter logic [15:0] VBASE_RESET = 16'hFF00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  irq_src,
  output logic        irq,
  output logic [15:0] irq_addr,
  input  logic        reset_irq,
  input  logic        cfg_write,
  input  logic [1:0]  cfg_addr,
  input  logic [15:0] cfg_wdata,
  output logic [15:0] cfg_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t      r_state;
  logic [7:0]  r_sync1;
  logic [7:0]  r_sync2;
  logic [7:0]  r_sync3;
  logic [7:0]  r_pend;
  logic [7:0]  r_mask;
  logic [15:0] r_vbase;
  logic [2:0]  r_id;
  logic        r_irq;
  logic [15:0] r_addr;

  logic [7:0]  w_edge;
  logic [7:0]  w_elig;
  logic [2:0]  w_win;
  logic        w_ack;
  logic        w_eoi;
  logic        w_w1c;
  logic [7:0]  w_clr;
  logic [15:0] w_vec;

  assign w_edge = r_sync2 & ~r_sync3;
  assign w_elig = r_pend & r_mask;
  assign w_ack  = (r_state == ASSERT) && reset_irq;
  assign w_eoi  = cfg_write && (cfg_addr == 2'd3);
  assign w_w1c  = cfg_write && (cfg_addr == 2'd1);
  assign w_clr  = (w_w1c ? cfg_wdata[7:0] : 8'h00)
                | (w_ack ? (8'(1) << r_id) : 8'h00);
  assign w_vec  = r_vbase + {11'b0, w_win, 2'b00};

  // Scan high to low so the lowest eligible index wins.
  always_comb begin
    w_win = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (w_elig[i]) w_win = 3'(i);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1 <= 8'h00;
      r_sync2 <= 8'h00;
      r_sync3 <= 8'h00;
      r_pend  <= 8'h00;
      r_mask  <= 8'h00;
      r_vbase <= VBASE_RESET;
    end else begin
      r_sync1 <= irq_src;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      // A fresh edge beats any clear landing in the same cycle.
      r_pend  <= (r_pend & ~w_clr) | w_edge;
      if (cfg_write && cfg_addr == 2'd0) r_mask <= cfg_wdata[7:0];
      if (cfg_write && cfg_addr == 2'd2) r_vbase <= cfg_wdata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_id    <= 3'd0;
      r_irq   <= 1'b0;
      r_addr  <= 16'h0000;
    end else begin
      case (r_state)
        IDLE: begin
          r_irq <= 1'b0;
          if (w_elig != 8'h00) begin
            r_id    <= w_win;
            r_addr  <= w_vec;
            r_irq   <= 1'b1;
            r_state <= ASSERT;
          end
        end
        ASSERT: begin
          if (reset_irq) begin
            r_irq   <= 1'b0;
            r_state <= SERVICE;
          end
        end
        SERVICE: begin
          r_irq <= 1'b0;
          if (w_eoi) r_state <= IDLE;
        end
        default: begin
          r_irq   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    cfg_rdata = 16'h0000;
    case (cfg_addr)
      2'd0: cfg_rdata = {8'h00, r_mask};
      2'd1: cfg_rdata = {8'h00, r_pend};
      2'd2: cfg_rdata = r_vbase;
      2'd3: cfg_rdata = {12'h000, r_state == SERVICE, r_id};
      default: cfg_rdata = 16'h0000;
    endcase
  end

  assign irq      = r_irq;
  assign irq_addr = r_addr;

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench for irq_controller: directed stimulus queues expected
// irq events and register reads; a forked monitor pops and compares them.
module tb_irq_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  irq_src = 8'h00;
  logic        irq;
  logic [15:0] irq_addr;
  logic        reset_irq = 1'b0;
  logic        cfg_write = 1'b0;
  logic [1:0]  cfg_addr = 2'd0;
  logic [15:0] cfg_wdata = 16'h0000;
  logic [15:0] cfg_rdata;

  irq_controller #(.VBASE_RESET(16'hFF00)) dut (
    .clock     (clock),
    .reset     (reset),
    .irq_src   (irq_src),
    .irq       (irq),
    .irq_addr  (irq_addr),
    .reset_irq (reset_irq),
    .cfg_write (cfg_write),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  int          irq_cyc_q[$];
  logic [15:0] irq_addr_q[$];
  string       irq_nm_q[$];
  logic [15:0] rd_exp_q[$];
  string       rd_nm_q[$];
  logic        rd_req = 1'b0;
  logic        irq_prev = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic mon_step();
    string nm;
    if (rd_req) begin
      if (rd_exp_q.size() == 0) begin
        chk("rd_no_expect", 32'd1, 32'd0);
      end else begin
        nm = rd_nm_q.pop_front();
        chk(nm, {16'h0, cfg_rdata}, {16'h0, rd_exp_q.pop_front()});
      end
    end
    if (irq && !irq_prev) begin
      if (irq_cyc_q.size() == 0) begin
        chk("unexpected_irq", 32'd1, 32'd0);
      end else begin
        nm = irq_nm_q.pop_front();
        chk({nm, "_cycle"}, cyc, irq_cyc_q.pop_front());
        chk({nm, "_addr"}, {16'h0, irq_addr},
            {16'h0, irq_addr_q.pop_front()});
      end
    end
    irq_prev = irq;
  endtask

  task automatic cyc_wait(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    cfg_write = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    cyc_wait(1);
    cfg_write = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [15:0] e,
                    input string nm);
    cfg_addr = a;
    rd_exp_q.push_back(e);
    rd_nm_q.push_back(nm);
    rd_req = 1'b1;
    cyc_wait(1);
    rd_req = 1'b0;
  endtask

  task automatic expect_irq(input int dly, input logic [15:0] a,
                            input string nm);
    irq_cyc_q.push_back(cyc + dly);
    irq_addr_q.push_back(a);
    irq_nm_q.push_back(nm);
  endtask

  // Pulse sources from IDLE; irq must rise 4 edges after the first sample.
  task automatic fire(input logic [7:0] b, input logic [15:0] a,
                      input string nm);
    expect_irq(4, a, nm);
    irq_src = b;
    cyc_wait(2);
    irq_src = 8'h00;
    cyc_wait(3);
  endtask

  task automatic ack();
    reset_irq = 1'b1;
    cyc_wait(1);
    reset_irq = 1'b0;
  endtask

  task automatic pulse_only(input logic [7:0] b);
    irq_src = b;
    cyc_wait(2);
    irq_src = 8'h00;
    cyc_wait(3);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clock);
        mon_step();
      end
    join_none

    cyc_wait(3);
    reset = 1'b0;
    cyc_wait(1);
    chk("rst_irq", {31'h0, irq}, 32'd0);
    chk("rst_irq_addr", {16'h0, irq_addr}, 32'h0);
    rd(2'd0, 16'h0000, "rst_mask");
    rd(2'd1, 16'h0000, "rst_pend");
    rd(2'd2, 16'hFF00, "rst_vbase");
    rd(2'd3, 16'h0000, "rst_status");

    // Basic vectored interrupt
    wr(2'd0, 16'h0004);
    wr(2'd2, 16'h1000);
    fire(8'h04, 16'h1008, "src2");
    rd(2'd3, 16'h0002, "src2_status_assert");
    ack();
    rd(2'd3, 16'h000A, "src2_status_service");
    rd(2'd1, 16'h0000, "src2_pend_cleared");
    wr(2'd3, 16'h0000);

    // Simultaneous edges: lowest index first, then the other
    wr(2'd0, 16'h00FF);
    fire(8'h22, 16'h1004, "src1_first");
    ack();
    expect_irq(2, 16'h1014, "src5_next");
    wr(2'd3, 16'h0000);
    cyc_wait(2);
    rd(2'd3, 16'h0005, "src5_status");
    ack();
    wr(2'd3, 16'h0000);

    // Masked pending, then enable
    wr(2'd0, 16'h0000);
    pulse_only(8'h08);
    rd(2'd1, 16'h0008, "masked_pend");
    expect_irq(2, 16'h100C, "src3_unmask");
    wr(2'd0, 16'h0008);
    cyc_wait(1);
    ack();
    wr(2'd3, 16'h0000);
    wr(2'd0, 16'h0000);
    pulse_only(8'h08);
    rd(2'd1, 16'h0008, "w1c_pend_before");
    wr(2'd1, 16'h0008);
    rd(2'd1, 16'h0000, "w1c_pend_after");
    wr(2'd0, 16'h0008);
    cyc_wait(5);
    rd(2'd3, 16'h0003, "w1c_no_irq_status");

    // No nesting in SERVICE; stray ack ignored
    wr(2'd0, 16'h0001);
    fire(8'h01, 16'h1000, "src0_a");
    ack();
    pulse_only(8'h01);
    cyc_wait(1);
    ack();
    rd(2'd3, 16'h0008, "svc_ack_ignored");
    rd(2'd1, 16'h0001, "svc_pend_kept");
    expect_irq(2, 16'h1000, "src0_b");
    wr(2'd3, 16'h0000);
    cyc_wait(2);
    ack();
    wr(2'd3, 16'h0000);

    // W1C of the active source in ASSERT keeps irq
    wr(2'd2, 16'hFFF8);
    fire(8'h01, 16'hFFF8, "src0_w1c");
    wr(2'd1, 16'h0001);
    chk("w1c_assert_irq_held", {31'h0, irq}, 32'd1);
    rd(2'd1, 16'h0000, "w1c_assert_pend");
    ack();
    wr(2'd3, 16'h0000);

    // Address wrap
    wr(2'd0, 16'h0080);
    fire(8'h80, 16'h0014, "src7_wrap");
    ack();
    wr(2'd3, 16'h0000);

    // Held-high source gives a single event
    wr(2'd0, 16'h0002);
    expect_irq(4, 16'hFFFC, "src1_held");
    irq_src = 8'h02;
    cyc_wait(5);
    ack();
    wr(2'd3, 16'h0000);
    cyc_wait(8);
    rd(2'd1, 16'h0000, "held_no_repend");
    irq_src = 8'h00;
    cyc_wait(3);

    // Async reset while ASSERT
    wr(2'd2, 16'h1000);
    wr(2'd0, 16'h0004);
    fire(8'h04, 16'h1008, "src2_pre_reset");
    irq_src = 8'h01;
    reset = 1'b1;
    #1;
    chk("areset_irq", {31'h0, irq}, 32'd0);
    chk("areset_irq_addr", {16'h0, irq_addr}, 32'h0);
    cfg_addr = 2'd1;
    #1;
    chk("areset_pend", {16'h0, cfg_rdata}, 32'h0);
    cfg_addr = 2'd0;
    #1;
    chk("areset_mask", {16'h0, cfg_rdata}, 32'h0);
    cfg_addr = 2'd2;
    #1;
    chk("areset_vbase", {16'h0, cfg_rdata}, 32'hFF00);
    cyc_wait(2);
    reset = 1'b0;
    cyc_wait(4);
    rd(2'd1, 16'h0001, "high_at_release_pend");
    expect_irq(2, 16'hFF00, "src0_post_reset");
    wr(2'd0, 16'h0001);
    cyc_wait(1);
    ack();
    wr(2'd3, 16'h0000);
    irq_src = 8'h00;
    cyc_wait(5);

    chk("irq_queue_drained", irq_cyc_q.size(), 32'd0);
    chk("rd_queue_drained", rd_exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
